// File: rtl/vec_pipe_unit_if.sv
// Request/response bundle for vec_pipe_unit: operand handshake in,
// result handshake out. Operands and results are flat, element i at
// bits [i*DATA_W +: DATA_W].
interface vec_pipe_unit_if #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                op;
  logic [DATA_W-1:0]         data_k;
  logic [WIDTH*DATA_W-1:0]   data_in1;
  logic [WIDTH*DATA_W-1:0]   data_in2;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH*DATA_W-1:0]   data_out;
  logic [DATA_W-1:0]         dot_out;
  logic                      sat;
  logic                      err;

  modport master (
    output in_valid, op, data_k, data_in1, data_in2, out_ready,
    input  in_ready, out_valid, data_out, dot_out, sat, err
  );

  modport slave (
    input  in_valid, op, data_k, data_in1, data_in2, out_ready,
    output in_ready, out_valid, data_out, dot_out, sat, err
  );
endinterface

// File: rtl/vec_pipe_unit.sv
// Multi-beat fixed-point vector ALU. One request is registered, LANES
// elements are computed per cycle over WIDTH/LANES beats, and the result
// is held until the consumer takes it.

// One element slice: saturating ADD/SUB/MUL/SCALE plus the raw A*B
// product for the DOT reduction.
module vec_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W-1:0]   k,
  output logic [DATA_W-1:0]   res,
  output logic                sat,
  output logic [2*DATA_W-1:0] prod
);
  localparam int PW = 2*DATA_W;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_SCALE = 3'd3;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] as, bs, ms;
  logic signed [PW-1:0]     ax, bx, mul_w, mul_sh, wide;
  logic [PW-DATA_W:0]       hi;
  logic                     arith;

  // Wide signed result, then clamp to DATA_W if the upper bits are not a sign extension
  always_comb begin
    as     = a;
    bs     = b;
    ms     = (op == OP_SCALE) ? k : b;
    ax     = PW'(as);
    bx     = PW'(bs);
    mul_w  = PW'(as) * PW'(ms);
    mul_sh = mul_w >>> FRAC;
    prod   = PW'(as) * PW'(bs);
    arith  = 1'b1;
    wide   = '0;
    case (op)
      OP_ADD:           wide = ax + bx;
      OP_SUB:           wide = ax - bx;
      OP_MUL, OP_SCALE: wide = mul_sh;
      default:          arith = 1'b0;
    endcase
    hi  = wide[PW-1:DATA_W-1];
    res = wide[DATA_W-1:0];
    sat = 1'b0;
    if (!arith) begin
      res = '0;
    end else if (!((&hi) || (~|hi))) begin
      res = wide[PW-1] ? MIN_V : MAX_V;
      sat = 1'b1;
    end
  end
endmodule

module vec_pipe_unit #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  vec_pipe_unit_if.slave bus
);
  localparam int N      = WIDTH / LANES;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW     = 2*DATA_W;
  localparam int ACC_W  = 2*DATA_W + $clog2(WIDTH);
  localparam logic [2:0] OP_DOT = 3'd4;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic                          sat_q, sat_d;
  logic                          err_q, err_d;
  logic [2:0]                    op_q, op_d;
  logic [DATA_W-1:0]             k_q, k_d;
  logic [DATA_W-1:0]             dot_q, dot_d;
  logic [WIDTH-1:0][DATA_W-1:0]  a_q, a_d, b_q, b_d, dout_q, dout_d;
  logic [WIDTH-1:0][DATA_W-1:0]  a_shift, b_shift, dout_shift;
  logic signed [ACC_W-1:0]       acc_q, acc_d, acc_sum, acc_sh;
  logic signed [PW-1:0]          p;
  logic [ACC_W-DATA_W:0]         acc_hi;
  logic                          dot_ovf;
  logic [DATA_W-1:0]             dot_sat;
  logic                          last_beat;

  logic [LANES-1:0][DATA_W-1:0]  lane_res;
  logic [LANES-1:0]              lane_sat;
  logic [LANES-1:0][PW-1:0]      lane_prod;

  // Operands slide down LANES elements per beat so the lanes always read
  // slots [LANES-1:0]; results enter at the top and land in place after N beats.
  if (N > 1) begin : g_multi
    assign a_shift    = {{(LANES*DATA_W){1'b0}}, a_q[WIDTH-1:LANES]};
    assign b_shift    = {{(LANES*DATA_W){1'b0}}, b_q[WIDTH-1:LANES]};
    assign dout_shift = {lane_res, dout_q[WIDTH-1:LANES]};
  end else begin : g_single
    assign a_shift    = a_q;
    assign b_shift    = b_q;
    assign dout_shift = lane_res;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vec_lane #(.DATA_W(DATA_W), .FRAC(FRAC)) u_lane (
      .op   (op_q),
      .a    (a_q[l]),
      .b    (b_q[l]),
      .k    (k_q),
      .res  (lane_res[l]),
      .sat  (lane_sat[l]),
      .prod (lane_prod[l])
    );
  end

  // Accumulate this beat's products; final scale and clamp for the DOT scalar
  always_comb begin
    acc_sum = acc_q;
    p       = '0;
    for (int l = 0; l < LANES; l++) begin
      p       = lane_prod[l];
      acc_sum = acc_sum + ACC_W'(p);
    end
    acc_sh  = acc_sum >>> FRAC;
    acc_hi  = acc_sh[ACC_W-1:DATA_W-1];
    dot_ovf = !((&acc_hi) || (~|acc_hi));
    dot_sat = dot_ovf ? (acc_sh[ACC_W-1] ? MIN_V : MAX_V) : acc_sh[DATA_W-1:0];
  end

  assign last_beat = (beat_q == BEAT_W'(N-1));

  // Control FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    err_d       = err_q;
    op_d        = op_q;
    k_d         = k_q;
    dot_d       = dot_q;
    a_d         = a_q;
    b_d         = b_q;
    dout_d      = dout_q;
    acc_d       = acc_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
          op_d       = bus.op;
          k_d        = bus.data_k;
          a_d        = bus.data_in1;
          b_d        = bus.data_in2;
          beat_d     = '0;
          sat_d      = 1'b0;
          err_d      = (bus.op > OP_DOT);
          acc_d      = '0;
          dout_d     = '0;
          dot_d      = '0;
        end
      end
      S_BUSY: begin
        a_d    = a_shift;
        b_d    = b_shift;
        dout_d = dout_shift;
        acc_d  = acc_sum;
        sat_d  = sat_q | (|lane_sat);
        beat_d = beat_q + 1'b1;
        if (last_beat) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (op_q == OP_DOT) begin
            dot_d = dot_sat;
            sat_d = sat_q | dot_ovf;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= '0;
      k_q         <= '0;
      dot_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      op_q        <= op_d;
      k_q         <= k_d;
      dot_q       <= dot_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = dout_q;
  assign bus.dot_out   = dot_q;
  assign bus.sat       = sat_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_vec_pipe_unit.sv
// Directed bench for vec_pipe_unit with WIDTH=8, LANES=2 (4 beats), Q8.8 data.
module tb_vec_pipe_unit;
  localparam int WIDTH = 8, LANES = 2, DATA_W = 16, FRAC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   lat;

  always #5 clk = ~clk;

  vec_pipe_unit_if #(.WIDTH(WIDTH), .DATA_W(DATA_W)) bus ();

  vec_pipe_unit #(.WIDTH(WIDTH), .LANES(LANES), .DATA_W(DATA_W), .FRAC(FRAC)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request with every element equal, return #1 after the accepting edge
  task automatic send(input logic [2:0] o, input logic [15:0] k, input logic [15:0] a,
                      input logic [15:0] b);
    int cnt;
    bus.op = o; bus.data_k = k;
    bus.data_in1 = {8{a}}; bus.data_in2 = {8{b}};
    bus.in_valid = 1'b1;
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("accept_wait", 128'(cnt < 20), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_in1 = '0; bus.data_in2 = '0; bus.data_k = '0; bus.op = 3'd0;
  endtask

  // Cycles from the accepting edge until out_valid, bounded
  task automatic wait_out(output int l);
    l = 0;
    while (!bus.out_valid && l < 20) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hs_out_valid", 128'(bus.out_valid), 128'(0));
    chk("hs_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic check_result(input string tag, input logic [15:0] elem, input logic [15:0] dot,
                              input logic s, input logic e);
    wait_out(lat);
    chk({tag, "_lat"}, 128'(lat), 128'(4));
    chk({tag, "_data"}, 128'(bus.data_out), 128'({8{elem}}));
    chk({tag, "_dot"}, 128'(bus.dot_out), 128'(dot));
    chk({tag, "_sat"}, 128'(bus.sat), 128'(s));
    chk({tag, "_err"}, 128'(bus.err), 128'(e));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.data_k = '0;
    bus.data_in1 = '0; bus.data_in2 = '0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_sat_err", 128'({bus.sat, bus.err}), 128'(0));
    chk("rst_data", 128'(bus.data_out), 128'(0));
    chk("rst_dot", 128'(bus.dot_out), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready_low", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_high", 128'(bus.in_ready), 128'(1));

    // ADD saturating high
    send(3'd0, 16'h0000, 16'h7000, 16'h2000);
    check_result("add_sat", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    handshake();

    // SUB saturating low
    send(3'd1, 16'h0000, 16'h8000, 16'h0001);
    check_result("sub_sat", 16'h8000, 16'h0000, 1'b1, 1'b0);
    handshake();

    // MUL 1.5 * 2.0
    send(3'd2, 16'h0000, 16'h0180, 16'h0200);
    check_result("mul", 16'h0300, 16'h0000, 1'b0, 1'b0);
    handshake();

    // SCALE -1.0 * 0.5, B ignored
    send(3'd3, 16'h0080, 16'hFF00, 16'h1234);
    check_result("scale", 16'hFF80, 16'h0000, 1'b0, 1'b0);
    handshake();

    // DOT 8 * (1.0*1.0)
    send(3'd4, 16'h0000, 16'h0100, 16'h0100);
    check_result("dot", 16'h0000, 16'h0800, 1'b0, 1'b0);
    handshake();

    // DOT overflow clamps
    send(3'd4, 16'h0000, 16'h4000, 16'h4000);
    check_result("dot_sat", 16'h0000, 16'h7FFF, 1'b1, 1'b0);
    handshake();

    // Backpressure: hold results 5 cycles with a competing request present
    send(3'd2, 16'h0000, 16'h0180, 16'h0200);
    check_result("bp", 16'h0300, 16'h0000, 1'b0, 1'b0);
    bus.op = 3'd0; bus.data_in1 = {8{16'h0001}}; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 128'(bus.data_out), 128'({8{16'h0300}}));
      chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_hold_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid = 1'b0; bus.data_in1 = '0;
    handshake();

    // Illegal op, operands that would otherwise saturate
    send(3'd6, 16'h0000, 16'h7000, 16'h7000);
    check_result("illegal", 16'h0000, 16'h0000, 1'b0, 1'b1);
    handshake();

    // Request held during BUSY/DONE is taken only once IDLE
    send(3'd0, 16'h0000, 16'h0001, 16'h0002);
    bus.op = 3'd1; bus.data_in1 = {8{16'h0010}}; bus.data_in2 = {8{16'h0003}};
    bus.in_valid = 1'b1;
    chk("gate_busy_ready", 128'(bus.in_ready), 128'(0));
    check_result("gate_first", 16'h0003, 16'h0000, 1'b0, 1'b0);
    handshake();
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.data_in1 = '0; bus.data_in2 = '0;
    chk("gate_taken", 128'(bus.in_ready), 128'(0));
    check_result("gate_second", 16'h000D, 16'h0000, 1'b0, 1'b0);
    handshake();

    // Reset during beat 2
    send(3'd0, 16'h0000, 16'h0100, 16'h0100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_data", 128'(bus.data_out), 128'(0));
    chk("mid_rst_flags", 128'({bus.in_ready, bus.sat, bus.err}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rel_ready_low", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    chk("mid_rel_ready_high", 128'(bus.in_ready), 128'(1));
    send(3'd0, 16'h0000, 16'h1000, 16'h0234);
    check_result("post_rst_add", 16'h1234, 16'h0000, 1'b0, 1'b0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
